// File: rtl/adsd_risc_pkg.sv
// Shared types and constants for the ADSD RISC control sequencer.
package adsd_risc_pkg;

   // Opcode map, taken from ir[15:12].
   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_ADDI  = 4'd7,
      OP_LW    = 4'd8,
      OP_SW    = 4'd9,
      OP_BEQ   = 4'd10,
      OP_BLT   = 4'd11,
      OP_JMP   = 4'd12,
      OP_RSV13 = 4'd13,
      OP_RSV14 = 4'd14,
      OP_HALT  = 4'd15
   } opcode_t;

   // ALU operation codes driven on ctrl_aluop.
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXEC   = 3'd1,
      ST_MEM    = 3'd2,
      ST_COMMIT = 3'd3,
      ST_HALTED = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/adsd_risc_ctrl_if.sv
// Control bus between the sequencer and the datapath / host controls.
interface adsd_risc_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic             step;
   logic [3:0]       opcode;
   logic             ctrl_zero;
   logic             ctrl_neg;
   logic             ctrl_ovf;
   logic             pc_ld;
   logic             ctrl_branch;
   logic             ctrl_jump;
   logic             ctrl_i_mem_oe;
   logic             ctrl_rf_rd_sel;
   logic             ctrl_rf_write_en;
   logic             ctrl_alu_in2_sel;
   logic             ctrl_d_mem_cs;
   logic             ctrl_d_mem_rw_;
   logic             ctrl_wdata_sel;
   logic [3:0]       ctrl_aluop;
   logic             halted;
   logic             busy;
   logic             ovf_flag;
   logic             ill_flag;
   logic [CNT_W-1:0] retired;

   // Sequencer side.
   modport slave (
      input  run, step, opcode, ctrl_zero, ctrl_neg, ctrl_ovf,
      output pc_ld, ctrl_branch, ctrl_jump, ctrl_i_mem_oe, ctrl_rf_rd_sel,
             ctrl_rf_write_en, ctrl_alu_in2_sel, ctrl_d_mem_cs, ctrl_d_mem_rw_,
             ctrl_wdata_sel, ctrl_aluop, halted, busy, ovf_flag, ill_flag, retired
   );

   // Datapath / host side.
   modport master (
      output run, step, opcode, ctrl_zero, ctrl_neg, ctrl_ovf,
      input  pc_ld, ctrl_branch, ctrl_jump, ctrl_i_mem_oe, ctrl_rf_rd_sel,
             ctrl_rf_write_en, ctrl_alu_in2_sel, ctrl_d_mem_cs, ctrl_d_mem_rw_,
             ctrl_wdata_sel, ctrl_aluop, halted, busy, ovf_flag, ill_flag, retired
   );
endinterface

// File: rtl/adsd_risc_decode.sv
// Combinational opcode decoder: static per-instruction control bits.
module adsd_risc_decode
   import adsd_risc_pkg::*;
(
   input  logic [3:0] opcode_i,
   output logic       rd_sel_o,
   output logic       alu_in2_sel_o,
   output logic [3:0] aluop_o,
   output logic       wdata_sel_o,
   output logic       writes_rf_o,
   output logic       is_mem_o,
   output logic       is_store_o,
   output logic       is_branch_o,
   output logic       is_jump_o,
   output logic       is_halt_o,
   output logic       illegal_o
);

   // Map each opcode to its static control bits; write data defaults to the ALU.
   always_comb begin
      rd_sel_o      = 1'b0;
      alu_in2_sel_o = 1'b0;
      aluop_o       = ALU_ADD;
      wdata_sel_o   = 1'b1;
      writes_rf_o   = 1'b0;
      is_mem_o      = 1'b0;
      is_store_o    = 1'b0;
      is_branch_o   = 1'b0;
      is_jump_o     = 1'b0;
      is_halt_o     = 1'b0;
      illegal_o     = 1'b0;
      case (opcode_i)
         OP_ADD:  begin rd_sel_o = 1'b1; writes_rf_o = 1'b1; aluop_o = ALU_ADD; end
         OP_SUB:  begin rd_sel_o = 1'b1; writes_rf_o = 1'b1; aluop_o = ALU_SUB; end
         OP_AND:  begin rd_sel_o = 1'b1; writes_rf_o = 1'b1; aluop_o = ALU_AND; end
         OP_OR:   begin rd_sel_o = 1'b1; writes_rf_o = 1'b1; aluop_o = ALU_OR;  end
         OP_XOR:  begin rd_sel_o = 1'b1; writes_rf_o = 1'b1; aluop_o = ALU_XOR; end
         OP_SLL:  begin rd_sel_o = 1'b1; writes_rf_o = 1'b1; aluop_o = ALU_SLL; end
         OP_SRL:  begin rd_sel_o = 1'b1; writes_rf_o = 1'b1; aluop_o = ALU_SRL; end
         OP_ADDI: begin alu_in2_sel_o = 1'b1; writes_rf_o = 1'b1; end
         // Loads take their write data from DMEM rather than the ALU.
         OP_LW:   begin alu_in2_sel_o = 1'b1; writes_rf_o = 1'b1; is_mem_o = 1'b1;
                        wdata_sel_o = 1'b0; end
         OP_SW:   begin alu_in2_sel_o = 1'b1; is_mem_o = 1'b1; is_store_o = 1'b1; end
         OP_BEQ,
         OP_BLT:  begin is_branch_o = 1'b1; aluop_o = ALU_SUB; end
         OP_JMP:  is_jump_o = 1'b1;
         OP_HALT: is_halt_o = 1'b1;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/adsd_risc_ctrl.sv
// Multi-cycle control sequencer for the 16-bit ADSD RISC datapath.
module adsd_risc_ctrl
   import adsd_risc_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter bit TRAP_ON_OVF = 1'b0
) (
   input logic              clk,
   input logic              rst,
   adsd_risc_ctrl_if.slave  bus
);

   ctrl_state_t      state_q, state_d;
   logic             step_mode_q, step_mode_d;
   logic             ovf_q, ovf_d;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic       dec_rd_sel, dec_alu_in2_sel, dec_wdata_sel, dec_writes_rf;
   logic       dec_is_mem, dec_is_store, dec_is_branch, dec_is_jump;
   logic       dec_is_halt, dec_illegal;
   logic [3:0] dec_aluop;

   logic       pc_ld, branch, jump, i_mem_oe, rd_sel, rf_we, alu_in2_sel;
   logic       d_mem_cs, d_mem_rw, wdata_sel, halted, busy;
   logic [3:0] aluop;
   logic       alu_write, br_cond;

   adsd_risc_decode u_decode (
      .opcode_i      (bus.opcode),
      .rd_sel_o      (dec_rd_sel),
      .alu_in2_sel_o (dec_alu_in2_sel),
      .aluop_o       (dec_aluop),
      .wdata_sel_o   (dec_wdata_sel),
      .writes_rf_o   (dec_writes_rf),
      .is_mem_o      (dec_is_mem),
      .is_store_o    (dec_is_store),
      .is_branch_o   (dec_is_branch),
      .is_jump_o     (dec_is_jump),
      .is_halt_o     (dec_is_halt),
      .illegal_o     (dec_illegal)
   );

   // ALU-result writers (opcodes 0-7) are the only ones that can overflow.
   assign alu_write = dec_writes_rf & dec_wdata_sel;
   assign br_cond   = (bus.opcode == OP_BLT) ? bus.ctrl_neg : bus.ctrl_zero;

   // Next-state, strobe generation and flag/counter updates.
   always_comb begin
      state_d     = state_q;
      step_mode_d = step_mode_q;
      ovf_d       = ovf_q;
      ill_d       = ill_q;
      retired_d   = retired_q;
      pc_ld       = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      i_mem_oe    = 1'b0;
      rd_sel      = 1'b0;
      rf_we       = 1'b0;
      alu_in2_sel = 1'b0;
      d_mem_cs    = 1'b0;
      d_mem_rw    = 1'b1;
      wdata_sel   = 1'b0;
      aluop       = ALU_ADD;
      halted      = 1'b0;
      busy        = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_COMMIT);

      // The instruction stays on the bus for its whole lifetime, so the
      // static decode holds from EXEC through COMMIT.
      if (busy) begin
         i_mem_oe    = 1'b1;
         aluop       = dec_aluop;
         rd_sel      = dec_rd_sel;
         alu_in2_sel = dec_alu_in2_sel;
         wdata_sel   = dec_wdata_sel;
      end

      case (state_q)
         ST_IDLE: begin
            // run takes priority, so a simultaneous step means continuous mode.
            if (bus.run || bus.step) begin
               state_d     = ST_EXEC;
               step_mode_d = !bus.run;
            end
         end
         ST_EXEC: begin
            if (dec_is_halt)     state_d = ST_HALTED;
            else if (dec_is_mem) state_d = ST_MEM;
            else                 state_d = ST_COMMIT;
         end
         ST_MEM: begin
            d_mem_cs = 1'b1;
            d_mem_rw = !dec_is_store;
            state_d  = ST_COMMIT;
         end
         ST_COMMIT: begin
            pc_ld     = 1'b1;
            rf_we     = dec_writes_rf;
            // Loads keep the read asserted while the register file captures it.
            if (dec_is_mem && !dec_is_store) d_mem_cs = 1'b1;
            branch    = dec_is_branch & br_cond;
            jump      = dec_is_jump;
            retired_d = retired_q + CNT_W'(1);
            if (alu_write && bus.ctrl_ovf) ovf_d = 1'b1;
            if (dec_illegal)               ill_d = 1'b1;
            if (TRAP_ON_OVF && alu_write && bus.ctrl_ovf) state_d = ST_HALTED;
            else if (step_mode_q || !bus.run)            state_d = ST_IDLE;
            else                                         state_d = ST_EXEC;
         end
         ST_HALTED: halted = 1'b1;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State, mode, sticky flags and retire counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         step_mode_q <= 1'b0;
         ovf_q       <= 1'b0;
         ill_q       <= 1'b0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         step_mode_q <= step_mode_d;
         ovf_q       <= ovf_d;
         ill_q       <= ill_d;
         retired_q   <= retired_d;
      end
   end

   assign bus.pc_ld            = pc_ld;
   assign bus.ctrl_branch      = branch;
   assign bus.ctrl_jump        = jump;
   assign bus.ctrl_i_mem_oe    = i_mem_oe;
   assign bus.ctrl_rf_rd_sel   = rd_sel;
   assign bus.ctrl_rf_write_en = rf_we;
   assign bus.ctrl_alu_in2_sel = alu_in2_sel;
   assign bus.ctrl_d_mem_cs    = d_mem_cs;
   assign bus.ctrl_d_mem_rw_   = d_mem_rw;
   assign bus.ctrl_wdata_sel   = wdata_sel;
   assign bus.ctrl_aluop       = aluop;
   assign bus.halted           = halted;
   assign bus.busy             = busy;
   assign bus.ovf_flag         = ovf_q;
   assign bus.ill_flag         = ill_q;
   assign bus.retired          = retired_q;

endmodule

// File: tb/tb_adsd_risc_ctrl.sv
// Scoreboard bench for adsd_risc_ctrl: directed instructions, per-cycle expected records.
module tb_adsd_risc_ctrl;

   localparam int CW = 16;
   // Hand-derived decode masks, bit n = opcode n.
   localparam logic [15:0] RDSEL_M = 16'h007F;  // R-type 0-6
   localparam logic [15:0] IN2_M   = 16'h0380;  // ADDI, LW, SW
   localparam logic [15:0] WE_M    = 16'h01FF;  // 0-8
   localparam logic [15:0] WSEL_M  = 16'hFEFF;  // all but LW

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic       fz = 1'b0, fn = 1'b0, fo = 1'b0;

   always #5 clk = ~clk;

   adsd_risc_ctrl_if #(.CNT_W(CW)) bus ();
   adsd_risc_ctrl_if #(.CNT_W(CW)) tbus ();

   assign bus.run = run;        assign tbus.run = run;
   assign bus.step = step;      assign tbus.step = step;
   assign bus.opcode = opcode;  assign tbus.opcode = opcode;
   assign bus.ctrl_zero = fz;   assign tbus.ctrl_zero = fz;
   assign bus.ctrl_neg = fn;    assign tbus.ctrl_neg = fn;
   assign bus.ctrl_ovf = fo;    assign tbus.ctrl_ovf = fo;

   adsd_risc_ctrl #(.CNT_W(CW), .TRAP_ON_OVF(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
   adsd_risc_ctrl #(.CNT_W(CW), .TRAP_ON_OVF(1'b1)) dut_trap (.clk(clk), .rst(rst), .bus(tbus));

   typedef struct packed {
      logic          pc_ld, br, jmp, imem, rdsel, we, in2, cs, rw, wsel;
      logic [3:0]    aluop;
      logic          halted, busy, ovf, ill;
      logic [CW-1:0] retired;
   } rec_t;

   rec_t          q[$];
   int            total = 0;
   int            bad = 0;
   logic [CW-1:0] exp_ret = '0;
   logic          exp_ovf = 1'b0;
   logic          exp_ill = 1'b0;

   function automatic rec_t sample();
      rec_t r;
      r.pc_ld = bus.pc_ld;            r.br = bus.ctrl_branch;
      r.jmp = bus.ctrl_jump;          r.imem = bus.ctrl_i_mem_oe;
      r.rdsel = bus.ctrl_rf_rd_sel;   r.we = bus.ctrl_rf_write_en;
      r.in2 = bus.ctrl_alu_in2_sel;   r.cs = bus.ctrl_d_mem_cs;
      r.rw = bus.ctrl_d_mem_rw_;      r.wsel = bus.ctrl_wdata_sel;
      r.aluop = bus.ctrl_aluop;       r.halted = bus.halted;
      r.busy = bus.busy;              r.ovf = bus.ovf_flag;
      r.ill = bus.ill_flag;           r.retired = bus.retired;
      return r;
   endfunction

   function automatic logic [3:0] alu_of(input logic [3:0] op);
      if (op <= 4'd6) return op;
      if (op == 4'd10 || op == 4'd11) return 4'd1;
      return 4'd0;
   endfunction

   // Expected record: active=0 gives the quiet (IDLE/reset) pattern.
   function automatic rec_t base(input logic [3:0] op, input logic active);
      rec_t r;
      r = '0;
      r.rw = 1'b1;
      r.ovf = exp_ovf;
      r.ill = exp_ill;
      r.retired = exp_ret;
      if (active) begin
         r.busy = 1'b1;
         r.imem = 1'b1;
         r.rdsel = RDSEL_M[op];
         r.in2 = IN2_M[op];
         r.wsel = WSEL_M[op];
         r.aluop = alu_of(op);
      end
      return r;
   endfunction

   task automatic check(input string name, input rec_t got, input rec_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic check_bits(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Push EXEC, optional MEM, and COMMIT records; advance the expected flags/counter.
   task automatic push_instr(input logic [3:0] op, input logic z, input logic n, input logic o);
      rec_t r;
      r = base(op, 1'b1);
      q.push_back(r);
      if (op == 4'd8 || op == 4'd9) begin
         r = base(op, 1'b1);
         r.cs = 1'b1;
         r.rw = (op != 4'd9);
         q.push_back(r);
      end
      r = base(op, 1'b1);
      r.pc_ld = 1'b1;
      r.we = WE_M[op];
      r.cs = (op == 4'd8);
      r.br = (op == 4'd10 && z) || (op == 4'd11 && n);
      r.jmp = (op == 4'd12);
      q.push_back(r);
      exp_ret = exp_ret + 1'b1;
      if (op <= 4'd7 && o) exp_ovf = 1'b1;
      if (op == 4'd13 || op == 4'd14) exp_ill = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: one-cycle step; 1: step held while busy; 2: one-cycle run pulse.
   task automatic do_instr(input string name, input logic [3:0] op, input logic z,
                           input logic n, input logic o, input int mode);
      int lat;
      lat = (op == 4'd8 || op == 4'd9) ? 3 : 2;
      opcode = op; fz = z; fn = n; fo = o;
      push_instr(op, z, n, o);
      if (mode == 2) run = 1'b1; else step = 1'b1;
      tick();
      if (mode != 1) begin step = 1'b0; run = 1'b0; end
      repeat (lat) tick();
      step = 1'b0;
      check(name, sample(), base(4'd0, 1'b0));
   endtask

   // Monitor: every cycle the DUT presents an instruction phase, pop and compare.
   always @(negedge clk) begin
      rec_t e;
      if (rst && (bus.busy || bus.halted)) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cycle got=%h want=none", sample());
         end else begin
            e = q.pop_front();
            check("cycle", sample(), e);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t r;
      // Reset with run=1 and ADD on the bus.
      run = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_main", sample(), base(4'd0, 1'b0));
      check_bits("reset_trap", {tbus.busy, tbus.halted, tbus.ctrl_d_mem_rw_, tbus.pc_ld},
                 {1'b0, 1'b0, 1'b1, 1'b0});

      // Two back-to-back ADDs in continuous mode; run drops during the second EXEC.
      opcode = 4'd0;
      push_instr(4'd0, 1'b0, 1'b0, 1'b0);
      push_instr(4'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();                 // IDLE -> EXEC
      tick();                 // -> COMMIT
      tick();                 // -> EXEC
      run = 1'b0;
      tick();                 // -> COMMIT
      tick();                 // -> IDLE
      check("run_add_idle", sample(), base(4'd0, 1'b0));

      do_instr("lw",        4'd8,  1'b0, 1'b0, 1'b0, 0);
      do_instr("sw",        4'd9,  1'b0, 1'b0, 1'b0, 0);
      do_instr("beq_taken", 4'd10, 1'b1, 1'b0, 1'b0, 0);
      do_instr("beq_not",   4'd10, 1'b0, 1'b1, 1'b0, 0);
      do_instr("blt_taken", 4'd11, 1'b0, 1'b1, 1'b0, 0);
      do_instr("blt_not",   4'd11, 1'b1, 1'b0, 1'b1, 0);
      check_bits("no_ovf_on_branch", {tbus.halted, bus.ovf_flag}, {1'b0, 1'b0});
      do_instr("jmp",       4'd12, 1'b1, 1'b1, 1'b0, 0);
      do_instr("sub",       4'd1,  1'b0, 1'b0, 1'b0, 0);
      do_instr("addi",      4'd7,  1'b0, 1'b0, 1'b0, 0);
      do_instr("sll_held",  4'd5,  1'b0, 1'b0, 1'b0, 1);
      do_instr("illegal13", 4'd13, 1'b0, 1'b0, 1'b0, 0);
      do_instr("lw_runpls", 4'd8,  1'b0, 1'b0, 1'b0, 2);
      do_instr("xor_runpls",4'd4,  1'b0, 1'b0, 1'b0, 2);
      do_instr("add_ovf",   4'd0,  1'b0, 1'b0, 1'b1, 0);
      check_bits("trap_halted", {tbus.halted, tbus.ovf_flag, tbus.busy, tbus.pc_ld, 12'd0, tbus.retired},
                 {1'b1, 1'b1, 1'b0, 1'b0, 12'd0, exp_ret});
      fo = 1'b0;

      // HALT with run held: no pc_ld, stays halted until reset.
      opcode = 4'd15;
      q.push_back(base(4'd15, 1'b1));
      r = base(4'd0, 1'b0);
      r.halted = 1'b1;
      repeat (3) q.push_back(r);
      run = 1'b1;
      tick();                 // -> EXEC
      tick();                 // -> HALTED
      repeat (3) tick();
      check("halt_persist", sample(), r);
      rst = 1'b0;
      #1;
      exp_ret = '0; exp_ovf = 1'b0; exp_ill = 1'b0;
      check("halt_reset", sample(), base(4'd0, 1'b0));
      check_bits("trap_reset", {tbus.halted, tbus.ovf_flag, 14'd0, tbus.retired},
                 {1'b0, 1'b0, 14'd0, 16'd0});
      run = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // Reset lands in the MEM cycle of an SW: the write strobe must collapse.
      opcode = 4'd9;
      r = base(4'd9, 1'b1);
      q.push_back(r);
      r.cs = 1'b1;
      r.rw = 1'b0;
      q.push_back(r);
      step = 1'b1;
      tick();                 // -> EXEC
      step = 1'b0;
      tick();                 // -> MEM
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("sw_reset_mem", sample(), base(4'd0, 1'b0));
      tick();
      rst = 1'b1;
      tick();
      check("sw_reset_idle", sample(), base(4'd0, 1'b0));

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain got=%0d want=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adsd_risc_ctrl.md
# adsd_risc_ctrl

Multi-cycle control sequencer for the 16-bit ADSD RISC datapath. Decodes the 4-bit opcode and steps each instruction through EXEC, optional MEM, and COMMIT states, driving every datapath control strobe. Provides run/single-step/halt control, sticky overflow and illegal-opcode flags, and a retired-instruction counter. Sits beside the datapath in the CPU top level, with the opcode and ALU flags fed back from the datapath.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `TRAP_ON_OVF`, default 0: when 1, an overflowing ALU instruction halts the core after it commits.
---
- `clk`, in, 1: clock. Everything happens on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `run`, in, 1: level. While high, instructions execute back to back.
- `step`, in, 1: single-cycle pulse. From IDLE, it executes exactly one instruction.
- `opcode`, in, 4: `ir[15:12]` from the datapath.
- `ctrl_zero`, `ctrl_neg`, `ctrl_ovf`, in, 1 each: ALU flags.
- `pc_ld`, out, 1: PC load strobe.
- `ctrl_branch`, `ctrl_jump`, out, 1 each: select the next-PC source.
- `ctrl_i_mem_oe`, out, 1: instruction ROM output enable.
- `ctrl_rf_rd_sel`, out, 1: destination field select. 1 selects `ir[3:0]`; 0 selects `ir[7:4]`.
- `ctrl_rf_write_en`, out, 1: register-file write enable.
- `ctrl_alu_in2_sel`, out, 1: 1 selects the sign-extended imm4.
- `ctrl_d_mem_cs`, out, 1: data memory chip select.
- `ctrl_d_mem_rw_`, out, 1: data memory direction. 1 = read, 0 = write.
- `ctrl_wdata_sel`, out, 1: register write-data source. 1 = ALU, 0 = DMEM.
- `ctrl_aluop`, out, 4: ALU operation code.
- `halted`, out, 1: core is in HALTED.
- `busy`, out, 1: an instruction is in flight.
- `ovf_flag`, `ill_flag`, out, 1 each: sticky overflow and illegal-opcode flags.
- `retired`, out, `CNT_W`: count of committed instructions.

## Operation
Opcode map, with the ALU operation each one drives:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL: R-type. `rd_sel` = 1; `alu_in2_sel` = 0.
- 7 ADDI: `rd_sel` = 0; `alu_in2_sel` = 1; ALU op ADD.
- 8 LW and 9 SW: address = rs + imm4, so `alu_in2_sel` = 1 and ALU op ADD.
- 10 BEQ (taken when `ctrl_zero`) and 11 BLT (taken when `ctrl_neg`): ALU op SUB of rs − rt.
- 12 JMP: next PC = sign-extended imm12.
- 15 HALT.
- 13 and 14 are illegal. They execute as NOP: PC advances and `ill_flag` is set.

States:
- IDLE: all strobes are 0. Go to EXEC when `run`=1 or `step`=1; latch `step_mode` = !`run`.
- EXEC: `i_mem_oe`=1; decode outputs are driven combinationally from `opcode`. Next state is MEM for LW/SW and COMMIT for everything else. HALT goes to HALTED and does not assert `pc_ld`.
- MEM: `cs`=1. For LW, `rw_`=1 and the read data is valid at the next edge. For SW, `rw_`=0 and the write lands on the edge that leaves MEM. Next state is COMMIT.
- COMMIT: `pc_ld`=1.
  - `rf_write_en`=1 for ALU ops, ADDI, and LW.
  - For LW, `cs`=1, `rw_`=1, `wdata_sel`=0.
  - `ctrl_branch` = (BEQ & zero) | (BLT & neg).
  - `ctrl_jump` = 1 for JMP.
  - `retired` increments.
  - Next state:
    - HALTED if `TRAP_ON_OVF` and `ovf` is set on an ALU op.
    - IDLE if `step_mode` is set or `run` is 0.
    - Otherwise EXEC.
- HALTED: all strobes are 0; `halted`=1. Only `rst` exits this state.

Flag and counter rules:
- `ovf_flag` sets in COMMIT when `ctrl_ovf`=1 and the opcode is 0–7.
- `retired` wraps modulo 2^`CNT_W`.
- While `i_mem_oe`=1, `ctrl_aluop` holds the decoded value in every state; otherwise it is 0.

## Timing
- Reset values: state IDLE; every output 0; `ctrl_d_mem_rw_`=1; `retired`=0; both flags 0.
- Latency: ALU, branch, JMP, and NOP take 2 cycles. LW and SW take 3 cycles. HALT takes 1 cycle, then stays in HALTED.
- `run` dropping mid-instruction: the instruction completes, then the FSM returns to IDLE. An instruction is never abandoned.
- `step` is ignored outside IDLE. If `run` and `step` are both high in IDLE, continuous mode wins.
- `rst` asserted mid-instruction: immediate return to IDLE with no PC load. For an SW, the write does not occur if reset asserts before the MEM exit edge.
- At most one `pc_ld` and one `rf_write_en` per instruction. Both fall in COMMIT and never in any other state.

## Structure
- The `adsd_risc_pkg` package holds:
  - the opcode enum (`OP_ADD` … `OP_HALT`);
  - the ALU-op constants (`ALU_ADD`=0, `SUB`=1, `AND`=2, `OR`=3, `XOR`=4, `SLL`=5, `SRL`=6);
  - the state enum `ctrl_state_t`.
- One sub-module, `adsd_risc_decode`: purely combinational, mapping `opcode` to the static control bits (`rd_sel`, `alu_in2_sel`, `aluop`, `wdata_sel`, `writes_rf`, `is_mem`, `is_store`, `is_branch`, `is_jump`, `is_halt`, `illegal`).
- The FSM, flags, and counter live in `adsd_risc_ctrl`.

## Test plan
- Reset with `run`=1, opcode 0 (ADD): EXEC then COMMIT. `pc_ld` and `rf_write_en` are high only in cycle 2, `rd_sel`=1, `aluop`=0, and `retired`=1.
- LW (8) with `run`=1: `cs`=1 in cycles 2–3, `rw_`=1, and in cycle 3 `wdata_sel`=0 with `rf_write_en`=1. SW (9): `cs`=1 and `rw_`=0 in cycle 2 only, with `rf_write_en` never asserted.
- BEQ with `zero`=1 gives `ctrl_branch`=1 in COMMIT; with `zero`=0 it gives 0. JMP (12) gives `ctrl_jump`=1 and `ctrl_branch`=0.
- `run`=0 plus a one-cycle `step` pulse: exactly one instruction executes, then the FSM returns to IDLE. A `step` asserted while busy has no effect.
- HALT (15): no `pc_ld`; `halted`=1 persists with `run`=1 until `rst` is asserted. Opcode 13 sets `ill_flag` and asserts `pc_ld`.
- `TRAP_ON_OVF`=1, ADD with `ovf`=1: COMMIT, then HALTED with `ovf_flag`=1. Also cover `rst` asserted during MEM of an SW: no `cs`/`rw_`=0 edge completes.
